// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS IF stage: PC, instruction memory and run-control FSM
//
// Holds the program counter and the instruction memory, and presents the
// fetched word plus PC+4 to the IF/ID register every cycle. A three-state
// FSM (IDLE / RUN / HALTED) gates program loading, fetching and draining.
//
// Ports:
//   i_clk, i_rst        clock (rising edge) and asynchronous active-high reset
//   i_start             IDLE -> RUN pulse
//   i_clear             HALTED -> IDLE pulse
//   i_step_mode, i_step single-step control; PC advances only on i_step
//   i_stall             hazard-unit hold request
//   i_branch_taken      redirect request, i_branch_target is the byte address
//   i_load_en/addr/data program-load write port, honoured only in IDLE
//   o_pc                PC+4 of the presented instruction
//   o_instruction       presented instruction (0 outside RUN)
//   o_halted            FSM is in HALTED

module instruction_fetch #(
    parameter int               NBITS      = 32,
    parameter int               IMEM_DEPTH = 256,
    parameter logic [NBITS-1:0] HALT_WORD  = 32'hFFFF_FFFF,
    localparam int              ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_clear,
    input  logic              i_step_mode,
    input  logic              i_step,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [NBITS-1:0]  i_branch_target,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [NBITS-1:0]  i_load_data,
    output logic [NBITS-1:0]  o_pc,
    output logic [NBITS-1:0]  o_instruction,
    output logic              o_halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           state_q;
    logic [NBITS-1:0] pc_q;
    logic             halted_q;

    logic [NBITS-1:0] mem [IMEM_DEPTH];

    logic [NBITS-1:0] word;
    logic [NBITS-1:0] pc_plus4;
    logic             advance;
    logic             load_we;

    // Byte-offset bits and bits above the memory span are dropped, so
    // addresses beyond the array wrap around.
    assign word     = mem[pc_q[ADDR_W+1:2]];
    assign pc_plus4 = pc_q + NBITS'(4);
    assign advance  = (state_q == S_RUN) && (!i_step_mode || i_step);

    // Gating on i_rst keeps a load that overlaps reset assertion from
    // landing at the edge.
    assign load_we  = !i_rst && (state_q == S_IDLE) && i_load_en;

    // Instruction memory has no reset so a loaded program survives i_rst.
    always_ff @(posedge i_clk) begin
        if (load_we) begin
            mem[i_load_addr] <= i_load_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pc_q <= '0;
                    if (i_start) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (advance) begin
                        // A taken branch squashes a HALT on the wrong path,
                        // and both branch and HALT win over a stall.
                        if (i_branch_taken) begin
                            pc_q <= i_branch_target;
                        end else if (word == HALT_WORD) begin
                            state_q  <= S_HALTED;
                            halted_q <= 1'b1;
                        end else if (!i_stall) begin
                            pc_q <= pc_plus4;
                        end
                    end
                end
                S_HALTED: begin
                    if (i_clear) begin
                        state_q  <= S_IDLE;
                        halted_q <= 1'b0;
                        pc_q     <= '0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    halted_q <= 1'b0;
                    pc_q     <= '0;
                end
            endcase
        end
    end

    // Outside RUN a zero (NOP) is presented so the pipeline drains cleanly.
    always_comb begin
        o_pc          = '0;
        o_instruction = '0;
        case (state_q)
            S_RUN: begin
                o_pc          = pc_plus4;
                o_instruction = word;
            end
            S_HALTED: begin
                o_pc = pc_plus4;
            end
            default: begin
                o_pc          = '0;
                o_instruction = '0;
            end
        endcase
    end

    assign o_halted = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch

module tb_instruction_fetch;

    localparam int          DEPTH  = 256;
    localparam int          AW     = 8;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
    localparam logic [31:0] W_A    = 32'h2001_0001;
    localparam logic [31:0] W_B    = 32'h2002_0002;
    localparam logic [31:0] W_C    = 32'h2003_0003;
    localparam logic [31:0] W_D    = 32'h2004_0004;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
    logic          stall = 1'b0;
    logic          branch = 1'b0;
    logic [31:0]   target = '0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;
    logic [31:0]   o_pc;
    logic [31:0]   o_instruction;
    logic          o_halted;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    logic [31:0] img [DEPTH];

    always #5 clk = ~clk;

    instruction_fetch dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_clear         (clear),
        .i_step_mode     (step_mode),
        .i_step          (step),
        .i_stall         (stall),
        .i_branch_taken  (branch),
        .i_branch_target (target),
        .i_load_en       (load_en),
        .i_load_addr     (load_addr),
        .i_load_data     (load_data),
        .o_pc            (o_pc),
        .o_instruction   (o_instruction),
        .o_halted        (o_halted)
    );

    // Reference model: mode is "idle", "run" or "halted" as a small int.
    int          m_mode = 0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_mem [DEPTH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0;
            m_pc   = '0;
        end else if (m_mode == 0) begin
            if (load_en) m_mem[int'(load_addr)] = load_data;
            if (start) begin
                m_mode = 1;
                m_pc   = '0;
            end
        end else if (m_mode == 1) begin
            if (!step_mode || step) begin
                if (branch) m_pc = target;
                else if (m_mem[(m_pc / 4) % DEPTH] == HALT) m_mode = 2;
                else if (!stall) m_pc = m_pc + 32'd4;
            end
        end else begin
            if (clear) begin
                m_mode = 0;
                m_pc   = '0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_pc", o_pc, (m_mode == 0) ? 32'd0 : m_pc + 32'd4);
            chk("model_instr", o_instruction,
                (m_mode == 1) ? m_mem[(m_pc / 4) % DEPTH] : 32'd0);
            chk("model_halted", {31'd0, o_halted}, {31'd0, m_mode == 2});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] ins, input logic [31:0] pc,
                              input logic hlt);
        chk({name, "_instr"}, o_instruction, ins);
        chk({name, "_pc"}, o_pc, pc);
        chk({name, "_halted"}, {31'd0, o_halted}, {31'd0, hlt});
    endtask

    initial begin
        logic [31:0] r;
        tick();
        rst = 1'b0;
        expect_out("reset", 32'd0, 32'd0, 1'b0);

        // Fill the whole memory so every fetch address is defined.
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom;
            if (r == HALT) r = 32'h0;
            img[i] = (i == 0) ? W_A : (i == 1) ? W_B : (i == 2) ? W_C : (i == 3) ? W_D : r;
            load_word(i, img[i]);
        end
        cmp_en = 1'b1;
        expect_out("idle_after_load", 32'd0, 32'd0, 1'b0);

        // Sequential fetch, stall at pc=8, branch overriding stall.
        start = 1'b1; tick(); start = 1'b0;
        expect_out("seq0", W_A, 32'd4, 1'b0);
        tick(); expect_out("seq1", W_B, 32'd8, 1'b0);
        tick(); expect_out("seq2", W_C, 32'd12, 1'b0);
        stall = 1'b1;
        tick(); expect_out("stall1", W_C, 32'd12, 1'b0);
        tick(); expect_out("stall2", W_C, 32'd12, 1'b0);
        branch = 1'b1; target = 32'h40;
        tick(); expect_out("branch_over_stall", img[16], 32'h44, 1'b0);
        branch = 1'b0; stall = 1'b0;
        tick(); expect_out("after_branch", img[17], 32'h48, 1'b0);

        // Load in RUN is ignored; branch past the array wraps to mem[1].
        load_word(1, 32'hDEAD_BEEF);
        branch = 1'b1; target = 32'(4 * DEPTH + 4);
        tick(); expect_out("wrap", W_B, 32'(4 * DEPTH + 8), 1'b0);
        branch = 1'b0;

        // Halt sequence.
        reset_pulse();
        load_word(2, HALT);
        start = 1'b1; tick(); start = 1'b0;
        expect_out("h0", W_A, 32'd4, 1'b0);
        tick(); expect_out("h1", W_B, 32'd8, 1'b0);
        tick(); expect_out("h_word", HALT, 32'd12, 1'b0);
        tick(); expect_out("halted", 32'd0, 32'd12, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        expect_out("halted_start_ignored", 32'd0, 32'd12, 1'b1);
        clear = 1'b1; tick(); clear = 1'b0;
        expect_out("cleared", 32'd0, 32'd0, 1'b0);
        load_word(2, W_C);

        // Asynchronous reset between edges, then rerun from retained memory.
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        expect_out("pre_rst", W_D, 32'd16, 1'b0);
        #2 rst = 1'b1;
        #1 expect_out("async_rst", 32'd0, 32'd0, 1'b0);
        tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        expect_out("rerun0", W_A, 32'd4, 1'b0);
        tick(); expect_out("rerun1", W_B, 32'd8, 1'b0);

        // Single-step mode.
        reset_pulse();
        step_mode = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            repeat (4) begin
                tick();
                chk("step_hold_pc", o_pc, 32'(4 * k));
            end
            step = 1'b1; tick(); step = 1'b0;
            chk("step_adv_pc", o_pc, 32'(4 * k + 4));
        end
        step = 1'b1; tick(); tick(); step = 1'b0;
        chk("step_multi_pc", o_pc, 32'd24);
        step_mode = 1'b0;

        // Randomized phase, checked every cycle by the model compare.
        reset_pulse();
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 249) == 0);
            start     = ($urandom_range(0, 11) == 0);
            clear     = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 63) == 0) step_mode = ~step_mode;
            step      = ($urandom_range(0, 2) == 0);
            stall     = ($urandom_range(0, 4) == 0);
            branch    = ($urandom_range(0, 7) == 0);
            target    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
            load_en   = ($urandom_range(0, 1) == 0);
            load_addr = AW'($urandom);
            load_data = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
            tick();
        end
        rst = 1'b0; start = 1'b0; clear = 1'b0; step = 1'b0;
        stall = 1'b0; branch = 1'b0; load_en = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the five-stage MIPS pipeline: holds the program counter, owns the instruction memory, and presents the fetched instruction plus PC+4 to the IF/ID pipeline register on every cycle. A small run-control FSM gates fetching: program loading in IDLE, normal or single-step fetching in RUN, and drain after a HALT word in HALTED. Branch/jump redirects come from downstream stages, and stall requests come from the hazard unit.

## Interface
- NBITS, 32, data/address width
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words (power of two); ADDR_W = clog2(IMEM_DEPTH)
- HALT_WORD, 32'hFFFF_FFFF, encoding that terminates execution

- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  pulse: IDLE->RUN
- i_clear  in  1  pulse: HALTED->IDLE
- i_step_mode  in  1  1 = PC advances only on i_step
- i_step  in  1  single-cycle advance pulse (step mode only)
- i_stall  in  1  hazard unit: hold PC
- i_branch_taken  in  1  redirect request
- i_branch_target  in  NBITS  redirect byte address
- i_load_en  in  1  program-load write strobe
- i_load_addr  in  ADDR_W  word address to write
- i_load_data  in  NBITS  instruction word to write
- o_pc  out  NBITS  PC+4 of the presented instruction, to IF/ID
- o_instruction  out  NBITS  presented instruction, to IF/ID
- o_halted  out  1  FSM in HALTED

## Operation
- State: pc register (NBITS), FSM {IDLE, RUN, HALTED}, memory mem[IMEM_DEPTH] (not reset).
- Read is combinational: word = mem[pc[ADDR_W+1:2]]; pc[1:0] ignored; pc bits above ADDR_W+1 ignored (wrap).
- advance = RUN & (~i_step_mode | i_step).
- IDLE: pc forced 0; o_pc=0, o_instruction=0 (NOP); i_load_en writes mem[i_load_addr]<=i_load_data. i_start -> RUN (pc stays 0).
- RUN, priority per edge:
  1. word==HALT_WORD & advance & ~i_branch_taken -> HALTED, pc held.
  2. advance & i_branch_taken -> pc<=i_branch_target (overrides i_stall).
  3. advance & i_stall -> pc held.
  4. advance -> pc<=pc+4, mod 2^NBITS.
  5. ~advance -> pc held.
- RUN outputs: o_instruction=word (HALT_WORD presented for its one fetch cycle), o_pc=pc+4.
- HALTED: pc held; o_instruction=0 so the pipeline drains; o_pc=pc+4; o_halted=1. i_clear -> IDLE. i_start ignored.
- i_load_en outside IDLE: ignored, memory unchanged. i_clear outside HALTED and i_start outside IDLE: ignored.
- A branch redirect in the same cycle as a fetched HALT_WORD takes the branch, because the HALT is on a squashed path.

## Timing
- Reset (async, immediate): pc=0, FSM=IDLE, o_pc=0, o_instruction=0, o_halted=0. Memory contents are preserved.
- Reset asserted mid-RUN or mid-load: operation aborts immediately, and no partial write completes after assertion.
- Load write: takes effect at the edge with i_load_en=1. The word is readable combinationally the next cycle.
- Fetch latency: 0 cycles from pc to o_instruction and o_pc (combinational). The IF/ID register samples them at the next edge.
- Redirect: i_branch_taken sampled at edge N. From N on, target is fetched, with no bubble inserted here. Squashing the wrong-path instruction is handled downstream.
- Stall: the same instruction/PC is presented for every stalled cycle.
- Step mode: exactly one PC update per i_step cycle. A multi-cycle i_step high gives one update per cycle.
- IDLE->RUN: first instruction (mem[0]) is presented in the cycle after the i_start edge.

## Test plan
- Sequential fetch: load mem[0..3]=A,B,C,D; pulse i_start -> o_instruction A,B,C,D on consecutive cycles with o_pc 4,8,12,16.
- Stall/redirect: during RUN at pc=8, hold i_stall 2 cycles -> C presented 3 cycles. Then i_branch_taken=1 with target 0x40 while i_stall=1 -> next cycle pc=0x40, o_pc=0x44.
- Halt: mem[2]=HALT_WORD -> HALT_WORD presented once at pc=8. Then o_halted=1, o_instruction=0, o_pc=12 held. i_clear -> IDLE, o_pc=0.
- Step mode: i_step_mode=1, pulse i_step 3 times, each separated by 4 idle cycles -> pc 0->4->8->12, with pc constant between pulses.
- Load guard/wrap: i_load_en in RUN does not alter memory. Branch to 4*IMEM_DEPTH+4 fetches mem[1].
- Async reset: assert i_rst between edges in RUN at pc=12 -> outputs 0 and FSM IDLE before the next edge. Memory retained, verified by rerunning.
